modulo_controlador_ataque: RTL and testbench

MODULO_CONTROLADOR_ATAQUE -- requirements
Module: modulo_controlador_ataque

---
 rtl/modulo_controlador_ataque_pkg.sv | 31 +++
 rtl/modulo_detector_borda.sv | 36 +++
 rtl/modulo_controlador_ataque.sv | 144 ++++++++++++++
 tb/tb_modulo_controlador_ataque.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/modulo_controlador_ataque_pkg.sv
// Shared types and constants for the attack controller: FSM states, status codes,
// board geometry and the (row, column) to map-bit index function.
`timescale 1ns/1ps
package modulo_controlador_ataque_pkg;

    localparam logic [2:0] ROWS = 3'd5;
    localparam logic [2:0] COLS = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        UPDATE = 3'd2,
        RESULT = 3'd3,
        END    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_WATER   = 2'b01,
        ST_HIT     = 2'b10,
        ST_INVALID = 2'b11
    } status_t;

    // Column-major map, row 0 in the most significant bit of each 5-bit column group.
    function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
        logic [5:0] base;
        base = {3'b000, c} * 6'd5;
        return base + (6'd4 - {3'b000, r});
    endfunction

endpackage

// File: rtl/modulo_detector_borda.sv
// Two-flop synchronizer and rising-edge detector for the confirm button.
// Stays disarmed after reset until the synchronized input has been seen low.
`timescale 1ns/1ps
module modulo_detector_borda (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic pulse
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic       armed;
    logic [1:0] primed;

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            armed  <= 1'b0;
            primed <= 2'b00;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            prev   <= sync2;
            primed <= {primed[0], 1'b1};
            // sync2 only holds a real sample once primed[1] is set; a held button never arms us
            armed  <= armed | (primed[1] & ~sync2);
        end
    end

    assign pulse = armed & sync2 & ~prev;

endmodule

// File: rtl/modulo_controlador_ataque.sv
// Attack controller: validates coordinates, marks the attacked map, counts hits, detects
// the end of game and scans the display. Optional attack budget via macro ATTACK_LIMIT_EN.
`timescale 1ns/1ps
import modulo_controlador_ataque_pkg::*;

module modulo_controlador_ataque #(
    parameter logic [15:0] SCAN_DIV    = 16'd50000,
    parameter logic [5:0]  MAX_ATTACKS = 6'd20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        button_confirmation,
    input  logic [5:0]  coord_at,
    input  logic [34:0] m_po,
    output logic [34:0] m_at,
    output logic [1:0]  status,
    output logic [5:0]  hits,
    output logic        busy,
    output logic        game_over,
    output logic [2:0]  col_sel,
    output logic [1:0]  dig_sel
);

    localparam logic [5:0] HITS_MAX = 6'd35;

    if (SCAN_DIV == 16'd0 || MAX_ATTACKS == 6'd0) begin : g_bad_param
        $error("SCAN_DIV and MAX_ATTACKS must be at least 1");
    end

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v >= HITS_MAX) ? v : v + 6'd1;
    endfunction

    state_t     state;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [5:0] idx;
    logic       pulse;
    logic       win;
    logic [15:0] div_q;

`ifdef ATTACK_LIMIT_EN
    logic [5:0] attacks;
`endif

    modulo_detector_borda u_detector (
        .clk   (clk),
        .clr   (clr),
        .din   (button_confirmation),
        .pulse (pulse)
    );

    assign idx = cell_idx(row_q, col_q);
    assign win = ((m_po & ~m_at) == 35'd0) && (m_po != 35'd0);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            m_at      <= 35'd0;
            status    <= ST_NONE;
            hits      <= 6'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
`ifdef ATTACK_LIMIT_EN
            attacks   <= 6'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pulse && !game_over) begin
                        row_q <= coord_at[5:3];
                        col_q <= coord_at[2:0];
                        state <= CHECK;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    // Range test first: idx is meaningless for out-of-board coordinates
                    if (row_q >= ROWS || col_q >= COLS) begin
                        status <= ST_INVALID;
                        state  <= RESULT;
                    end else if (m_at[idx]) begin
                        status <= ST_INVALID;
                        state  <= RESULT;
                    end else begin
                        state  <= UPDATE;
                    end
                end
                UPDATE: begin
                    m_at[idx] <= 1'b1;
                    if (m_po[idx]) begin
                        hits   <= sat_inc(hits);
                        status <= ST_HIT;
                    end else begin
                        status <= ST_WATER;
                    end
`ifdef ATTACK_LIMIT_EN
                    attacks <= sat_inc(attacks);
`endif
                    state <= RESULT;
                end
                RESULT: begin
`ifdef ATTACK_LIMIT_EN
                    if (win || attacks >= MAX_ATTACKS) begin
`else
                    if (win) begin
`endif
                        state     <= END;
                        game_over <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                END: begin
                    game_over <= 1'b1;
                    busy      <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Display scan runs independently of the FSM
    always_ff @(posedge clk) begin
        if (!clr) begin
            div_q   <= 16'd0;
            col_sel <= 3'd0;
            dig_sel <= 2'd0;
        end else if (div_q >= SCAN_DIV - 16'd1) begin
            div_q   <= 16'd0;
            col_sel <= (col_sel == 3'd6) ? 3'd0 : col_sel + 3'd1;
            dig_sel <= (dig_sel == 2'd2) ? 2'd0 : dig_sel + 2'd1;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_modulo_controlador_ataque.sv
// Directed bench for modulo_controlador_ataque with immediate assertions at each check.
// Define ATTACK_LIMIT_EN for both RTL and bench to exercise the attack budget.
`timescale 1ns/1ps
module tb_modulo_controlador_ataque;

    logic        clk = 1'b0;
    logic        clr;
    logic        button;
    logic [5:0]  coord;
    logic [34:0] m_po;
    logic [34:0] m_at;
    logic [1:0]  status;
    logic [5:0]  hits;
    logic        busy;
    logic        game_over;
    logic [2:0]  col_sel;
    logic [1:0]  dig_sel;

    int n_assert = 0;
    int n_fail   = 0;

    modulo_controlador_ataque #(
        .SCAN_DIV    (16'd2),
        .MAX_ATTACKS (6'd2)
    ) dut (
        .clk                 (clk),
        .clr                 (clr),
        .button_confirmation (button),
        .coord_at            (coord),
        .m_po                (m_po),
        .m_at                (m_at),
        .status              (status),
        .hits                (hits),
        .busy                (busy),
        .game_over           (game_over),
        .col_sel             (col_sel),
        .dig_sel             (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] bit_at(input int r, input int c);
        logic [34:0] one;
        one = 35'd1;
        return one << (c * 5 + 4 - r);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic attack(input logic [2:0] r, input logic [2:0] c, input int hold);
        coord  = {r, c};
        button = 1'b1;
        cycles(hold);
        button = 1'b0;
        cycles(10);
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("busy_rise", {34'd0, busy}, 35'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_m_at"}, m_at, 35'd0);
        check({tag, "_status"}, {33'd0, status}, 35'd0);
        check({tag, "_hits"}, {29'd0, hits}, 35'd0);
        check({tag, "_busy"}, {34'd0, busy}, 35'd0);
        check({tag, "_game_over"}, {34'd0, game_over}, 35'd0);
        check({tag, "_col_sel"}, {32'd0, col_sel}, 35'd0);
        check({tag, "_dig_sel"}, {33'd0, dig_sel}, 35'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr    = 1'b0;
        button = 1'b0;
        coord  = 6'd0;
        m_po   = 35'd0;
        cycles(3);
        check_reset_state("reset");

        // Scan: with SCAN_DIV=2 the selectors advance on every second edge
        clr = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            check("scan_col", {32'd0, col_sel}, 35'((k / 2) % 7));
            check("scan_dig", {33'd0, dig_sel}, 35'((k / 2) % 3));
        end

        // Single-ship win with latency check
        m_po   = bit_at(0, 6);
        coord  = {3'd0, 3'd6};
        button = 1'b1;
        wait_busy();
        check("lat_check_m_at", m_at, 35'd0);
        cycles(1);
        check("lat_update_m_at", m_at, 35'd0);
        cycles(1);
        check("win_m_at", m_at, bit_at(0, 6));
        check("win_status", {33'd0, status}, 35'd2);
        check("win_hits", {29'd0, hits}, 35'd1);
        cycles(1);
        check("win_game_over", {34'd0, game_over}, 35'd1);
        button = 1'b0;
        cycles(5);
        attack(3'd0, 3'd0, 2);
        check("end_ignore_m_at", m_at, bit_at(0, 6));
        check("end_ignore_hits", {29'd0, hits}, 35'd1);
        check("end_game_over", {34'd0, game_over}, 35'd1);

        // Reset with the button held through release
        button = 1'b1;
        clr    = 1'b0;
        cycles(2);
        check_reset_state("reset2");
        clr = 1'b1;
        cycles(20);
        check("held_busy", {34'd0, busy}, 35'd0);
        check("held_m_at", m_at, 35'd0);
        check("held_status", {33'd0, status}, 35'd0);
        button = 1'b0;
        cycles(5);

`ifndef ATTACK_LIMIT_EN
        m_po = bit_at(4, 0) | bit_at(0, 6);
        attack(3'd4, 3'd0, 2);
        check("hit40_m_at", m_at, bit_at(4, 0));
        check("hit40_status", {33'd0, status}, 35'd2);
        check("hit40_hits", {29'd0, hits}, 35'd1);
        check("hit40_game_over", {34'd0, game_over}, 35'd0);
        attack(3'd1, 3'd1, 2);
        check("water11_status", {33'd0, status}, 35'd1);
        check("water11_m_at", m_at, bit_at(4, 0) | bit_at(1, 1));
        attack(3'd4, 3'd0, 2);
        check("repeat_status", {33'd0, status}, 35'd3);
        check("repeat_m_at", m_at, bit_at(4, 0) | bit_at(1, 1));
        check("repeat_hits", {29'd0, hits}, 35'd1);
        attack(3'd5, 3'd0, 2);
        check("row5_status", {33'd0, status}, 35'd3);
        check("row5_m_at", m_at, bit_at(4, 0) | bit_at(1, 1));
        check("row5_hits", {29'd0, hits}, 35'd1);
        attack(3'd0, 3'd7, 2);
        check("col7_status", {33'd0, status}, 35'd3);
        check("col7_m_at", m_at, bit_at(4, 0) | bit_at(1, 1));

        // Long press: a second attack would report a repeat
        attack(3'd2, 3'd2, 100);
        check("long_status", {33'd0, status}, 35'd1);
        check("long_m_at", m_at, bit_at(4, 0) | bit_at(1, 1) | bit_at(2, 2));
        check("long_busy", {34'd0, busy}, 35'd0);

        // Second press lands while the first attack is still in flight
        coord  = {3'd3, 3'd3};
        button = 1'b1;
        cycles(2);
        button = 1'b0;
        cycles(1);
        coord  = {3'd3, 3'd4};
        button = 1'b1;
        cycles(2);
        button = 1'b0;
        cycles(10);
        check("busy_press_m_at", m_at, bit_at(4, 0) | bit_at(1, 1) | bit_at(2, 2) | bit_at(3, 3));
        check("busy_press_status", {33'd0, status}, 35'd1);

        // Reset while the FSM sits in UPDATE
        coord  = {3'd0, 3'd0};
        button = 1'b1;
        wait_busy();
        button = 1'b0;
        cycles(1);
        clr = 1'b0;
        cycles(1);
        check_reset_state("abort");
        clr = 1'b1;
        cycles(3);
`else
        m_po = bit_at(0, 6);
        attack(3'd0, 3'd0, 2);
        check("lim1_status", {33'd0, status}, 35'd1);
        check("lim1_game_over", {34'd0, game_over}, 35'd0);
        attack(3'd1, 3'd0, 2);
        check("lim2_status", {33'd0, status}, 35'd1);
        check("lim2_game_over", {34'd0, game_over}, 35'd1);
        attack(3'd0, 3'd6, 2);
        check("lim_ignore_m_at", m_at, bit_at(0, 0) | bit_at(1, 0));
        check("lim_ignore_hits", {29'd0, hits}, 35'd0);
        check("lim_ignore_game_over", {34'd0, game_over}, 35'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
